// File: rtl/kypd_pkg.sv
// kypd_pkg -- definitions shared by the keypad event logic and the game logic.
//   KEY_W          : width of a decoded key code
//   kypd_state_e   : debounce FSM states
//   KEY_* codes    : digit keys 0-9 and operator keys A-F
//   is_digit()     : true for the numeric keys
package kypd_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } kypd_state_e;

  localparam logic [KEY_W-1:0] KEY_0   = 4'h0;
  localparam logic [KEY_W-1:0] KEY_1   = 4'h1;
  localparam logic [KEY_W-1:0] KEY_2   = 4'h2;
  localparam logic [KEY_W-1:0] KEY_3   = 4'h3;
  localparam logic [KEY_W-1:0] KEY_4   = 4'h4;
  localparam logic [KEY_W-1:0] KEY_5   = 4'h5;
  localparam logic [KEY_W-1:0] KEY_6   = 4'h6;
  localparam logic [KEY_W-1:0] KEY_7   = 4'h7;
  localparam logic [KEY_W-1:0] KEY_8   = 4'h8;
  localparam logic [KEY_W-1:0] KEY_9   = 4'h9;
  localparam logic [KEY_W-1:0] KEY_ADD = 4'hA;
  localparam logic [KEY_W-1:0] KEY_SUB = 4'hB;
  localparam logic [KEY_W-1:0] KEY_MUL = 4'hC;
  localparam logic [KEY_W-1:0] KEY_DIV = 4'hD;
  localparam logic [KEY_W-1:0] KEY_EQ  = 4'hE;
  localparam logic [KEY_W-1:0] KEY_CLR = 4'hF;

  function automatic logic is_digit(input logic [KEY_W-1:0] k);
    return (k <= KEY_9);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// key_fifo -- small synchronous FIFO for debounced key events.
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : request to enqueue push_data_i
//   push_data_i  : key code to enqueue
//   pop_i        : request to dequeue the head (ignored while empty)
//   head_o       : oldest entry (0 after reset)
//   empty_o      : no entries queued
//   full_o       : DEPTH entries queued
//   ovf_set_o    : one-cycle pulse when a push is dropped because the queue is full
module key_fifo
  import kypd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             ovf_set_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_en, push_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop_en    = pop_i && !empty_o;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign push_en   = push_i && (!full_o || pop_en);
  assign ovf_set_o = push_i && full_o && !pop_en;

  assign head_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage entries are cleared on reset so head_o reads 0 when empty.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else if (push_en && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
          mem_q[gi] <= push_data_i;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/kypd_key_event.sv
// kypd_key_event -- debounces keypad presses into single key events and
// queues them for a consumer.
//   clk, rst   : clock, synchronous active-high reset
//   key_code   : decoded key value from the keypad decoder
//   key_down   : raw (bouncy) "some key pressed" indication
//   key_out    : oldest queued key code
//   key_valid  : queue non-empty
//   key_ack    : consumer pops the head when key_valid && key_ack
//   overflow   : sticky, a debounced press was dropped on a full queue
module kypd_key_event
  import kypd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_code,
  input  logic             key_down,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             overflow
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  kypd_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [KEY_W-1:0] cap_q;
  logic             overflow_q, overflow_d;

  logic             push_evt;
  logic             fifo_empty, fifo_full, fifo_ovf_set;

  // The event is pushed in the same cycle the last stable sample is seen,
  // so it is decoded from current state rather than registered.
  assign push_evt = (state_q == PRESS_WAIT) && key_down &&
                    (key_code == cap_q) && (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_down) begin
            state_q <= PRESS_WAIT;
            cap_q   <= key_code;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!key_down) begin
            state_q <= IDLE;
          end else if (key_code != cap_q) begin
            // Decoder settled on a different key: restart with the new code.
            cap_q <= key_code;
            cnt_q <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= HELD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          // Code changes while held are ignored: one event per press.
          if (!key_down) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (key_down) begin
            state_q <= HELD;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_evt),
    .push_data_i (cap_q),
    .pop_i       (key_ack),
    .head_o      (key_out),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .ovf_set_o   (fifo_ovf_set)
  );

  assign key_valid = !fifo_empty;

  // A drop can only happen against a full queue; qualifying with full keeps
  // the flag immune to any glitch on the pulse outside that condition.
  assign overflow_d = overflow_q | (fifo_ovf_set & fifo_full);

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_kypd_key_event.sv
module tb_kypd_key_event;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_code;
  logic       key_down;
  logic [3:0] key_out;
  logic       key_valid;
  logic       key_ack;
  logic       overflow;

  int total  = 0;
  int passed = 0;

  logic [3:0] exp_q [$];

  kypd_key_event #(
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_code  (key_code),
    .key_down  (key_down),
    .key_out   (key_out),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    $display("check %-20s observed=%0h expected=%0h", tag, got, exp);
  endtask

  // Full press/release; the bench model predicts whether the event fits.
  task automatic press(input logic [3:0] code, input string tag);
    if (exp_q.size() < 4) exp_q.push_back(code);
    key_code = code;
    key_down = 1'b1;
    step(6);
    key_down = 1'b0;
    step(6);
    $display("press %s code=%0h queued_model=%0d", tag, code, exp_q.size());
  endtask

  // Wait (bounded) for an event, compare against the scoreboard, then pop.
  task automatic consume(input string tag);
    int         waited = 0;
    logic [3:0] e;
    while (!key_valid && waited < 20) begin
      step(1);
      waited++;
    end
    chk({tag, "_valid"}, 32'(key_valid), 32'd1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = 4'hx;
    chk({tag, "_code"}, 32'(key_out), 32'(e));
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
  endtask

  initial begin
    logic [9:0] bounce;
    rst = 1'b1; key_code = 4'h0; key_down = 1'b0; key_ack = 1'b0;
    step(2);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_key_out", 32'(key_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    step(1);

    // Clean press: event visible after the 5th edge, not before.
    key_code = 4'h7; key_down = 1'b1;
    exp_q.push_back(4'h7);
    step(4);
    chk("clean_early", 32'(key_valid), 32'd0);
    step(1);
    chk("clean_valid", 32'(key_valid), 32'd1);
    chk("clean_code", 32'(key_out), 32'h7);
    step(5);
    key_down = 1'b0;
    step(6);
    consume("clean_pop");
    chk("clean_single", 32'(key_valid), 32'd0);

    // Bounce: pattern index 0 is the first sample; event only at the end.
    bounce = 10'b1111101101;
    key_code = 4'h3;
    exp_q.push_back(4'h3);
    for (int i = 0; i < 10; i++) begin
      key_down = bounce[i];
      step(1);
      chk($sformatf("bounce_v%0d", i), 32'(key_valid), (i == 9) ? 32'd1 : 32'd0);
    end
    key_down = 1'b0;
    step(6);
    consume("bounce_pop");
    chk("bounce_single", 32'(key_valid), 32'd0);

    // Code change while debouncing: only the settled code is reported.
    key_down = 1'b1; key_code = 4'h2;
    exp_q.push_back(4'hA);
    step(2);
    key_code = 4'hA;
    step(6);
    key_down = 1'b0;
    step(6);
    consume("chg_pop");
    chk("chg_single", 32'(key_valid), 32'd0);

    // Overflow: five presses, nobody popping.
    press(4'h1, "ovf1"); press(4'h2, "ovf2"); press(4'h3, "ovf3"); press(4'h4, "ovf4");
    chk("ovf_before", 32'(overflow), 32'd0);
    press(4'h5, "ovf5");
    chk("ovf_after", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) consume($sformatf("ovf_pop%0d", i));
    chk("ovf_drained", 32'(key_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Push and pop on the same edge while full.
    press(4'h6, "fp1"); press(4'h7, "fp2"); press(4'h8, "fp3"); press(4'h9, "fp4");
    key_code = 4'hB; key_down = 1'b1;
    step(4);
    chk("fp_head_before", 32'(key_out), 32'(exp_q[0]));
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(4'hB);
    chk("fp_head_after", 32'(key_out), 32'(exp_q[0]));
    chk("fp_overflow", 32'(overflow), 32'd0);
    key_down = 1'b0;
    step(6);
    for (int i = 0; i < 4; i++) consume($sformatf("fp_pop%0d", i));
    chk("fp_drained", 32'(key_valid), 32'd0);

    // Reset during PRESS_WAIT discards the press.
    key_code = 4'hC; key_down = 1'b1;
    step(2);
    rst = 1'b1; key_down = 1'b0;
    step(1);
    rst = 1'b0;
    chk("rstpw_valid", 32'(key_valid), 32'd0);
    step(8);
    chk("rstpw_no_stale", 32'(key_valid), 32'd0);

    // Reset with two entries queued flushes them.
    press(4'hD, "rq1"); press(4'hE, "rq2");
    chk("rq_valid", 32'(key_valid), 32'd1);
    rst = 1'b1; step(1); rst = 1'b0;
    exp_q.delete();
    chk("rq_valid_clr", 32'(key_valid), 32'd0);
    chk("rq_key_out_clr", 32'(key_out), 32'd0);
    chk("rq_overflow_clr", 32'(overflow), 32'd0);
    step(8);
    chk("rq_no_stale", 32'(key_valid), 32'd0);

    // Key already held when reset releases: fresh event after debounce.
    key_code = 4'h5; key_down = 1'b1;
    rst = 1'b1; step(1); rst = 1'b0;
    exp_q.push_back(4'h5);
    step(4);
    chk("held_early", 32'(key_valid), 32'd0);
    step(1);
    chk("held_valid", 32'(key_valid), 32'd1);
    key_down = 1'b0;
    step(6);
    consume("held_pop");
    chk("held_single", 32'(key_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/kypd_key_event.md
KYPD_KEY_EVENT -- requirements
Module: kypd_key_event

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable cycles required to accept a press or release (10 ms at 100 MHz); legal range is 2 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning key-event queue entries; it SHALL be a power of two, 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-005 SHALL have port key_code, input, 4 bits: the decoded key value from the keypad decoder, in the clk domain.
REQ-006 SHALL have port key_down, input, 1 bit: high while any key is physically pressed (raw, bouncy), in the clk domain.
REQ-007 SHALL have port key_out, output, 4 bits: the oldest queued key code (FIFO head).
REQ-008 SHALL have port key_valid, output, 1 bit: high while the queue is non-empty.
REQ-009 SHALL have port key_ack, input, 1 bit: the consumer pops the head on any cycle where key_valid and key_ack are both high.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set when a debounced press is dropped because the queue is full.

Function
REQ-011 SHALL implement an FSM with four states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-012 In IDLE with key_down=1, the FSM SHALL go to PRESS_WAIT, capture key_code into cap_code, and clear cnt to 0.
REQ-013 In PRESS_WAIT with key_down=0, the FSM SHALL return to IDLE with no push.
REQ-014 In PRESS_WAIT with key_down=1 and key_code not equal to cap_code, the FSM SHALL recapture cap_code, clear cnt to 0, and stay in PRESS_WAIT.
REQ-015 In PRESS_WAIT with key_down=1 and key_code equal to cap_code:
- if cnt equals DEBOUNCE_CYCLES-1, the FSM SHALL push cap_code and go to HELD;
- otherwise it SHALL increment cnt.
REQ-016 In HELD, key_code changes SHALL be ignored, giving no auto-repeat and no second event; key_down=0 SHALL move the FSM to RELEASE_WAIT with cnt cleared to 0.
REQ-017 In RELEASE_WAIT with key_down=1, the FSM SHALL return to HELD, treating the low pulse as bounce.
REQ-018 In RELEASE_WAIT with key_down=0, the FSM SHALL go to IDLE when cnt equals DEBOUNCE_CYCLES-1, and otherwise increment cnt.
REQ-019 Latency: with key_down first sampled high at cycle 0 and key_code stable, the push SHALL occur at the end of cycle DEBOUNCE_CYCLES, and key_valid SHALL be high from cycle DEBOUNCE_CYCLES+1.
REQ-020 cnt SHALL be sized with $clog2(DEBOUNCE_CYCLES) bits and SHALL never wrap.
REQ-021 The queue SHALL be a FIFO_DEPTH-entry FIFO; key_out and key_valid SHALL be registered state only, with no combinational path from key_ack.
REQ-022 A pop with the queue empty SHALL be ignored.
REQ-023 A push with the queue full and no pop SHALL be dropped and SHALL set overflow.
REQ-024 A push and a pop in the same cycle when full SHALL both take effect, with occupancy unchanged and overflow not set.
REQ-025 A push and a pop in the same cycle when empty is not possible, because a pop requires key_valid.
REQ-026 The read and write pointers SHALL wrap modulo FIFO_DEPTH, using an extra MSB or an occupancy counter to distinguish full from empty.
REQ-027 overflow SHALL stay high until rst.

Reset
REQ-028 On rst=1 at a clock edge:
- the FSM SHALL go to IDLE;
- cnt, cap_code, the FIFO pointers and occupancy SHALL clear to 0;
- key_valid SHALL be 0, key_out SHALL be 4'h0, and overflow SHALL be 0.
REQ-029 rst SHALL take priority over every other event, including a push or pop in the same cycle; a press in progress SHALL be discarded.
REQ-030 After rst deasserts with key_down already high, the FSM SHALL start from IDLE, so a held key produces a fresh event after debounce.

Structure
REQ-031 Package kypd_pkg SHALL hold the FSM state enum, KEY_W=4, and the key-code constants shared with the game logic (digits 0-9, operator codes A-F).
REQ-032 The FIFO SHALL be the sub-module key_fifo (parameters DEPTH and WIDTH), with ports for push, push data, pop, head, empty, full, and the overflow-set pulse.
REQ-033 kypd_key_event SHALL hold only the debounce FSM, the counter, and the instantiation of key_fifo.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-034 Clean press: key_code=4'h7 and key_down=1 held for 10 cycles from cycle 0 -> key_valid rises at cycle 5 with key_out=4'h7; exactly one event is produced.
REQ-035 Bounce: key_down pattern 1,0,1,1,0,1,1,1,1,1 with key_code=4'h3 -> a single event 4'h3, pushed 4 stable cycles after the last low sample, is the only event.
REQ-036 Code change: key_code goes 4'h2 for 2 cycles, then 4'hA, with key_down=1 throughout -> a single event 4'hA; no event for 4'h2.
REQ-037 Overflow: 5 clean presses with releases and key_ack=0 -> the queue holds 4 events, overflow=1 after the 5th press, and pops return the first four codes in order.
REQ-038 Full push and pop: the 5th press completes on the same cycle as key_ack=1 -> overflow=0, occupancy stays 4, and the head advances.
REQ-039 Mid-operation reset: rst pulses for 1 cycle during PRESS_WAIT and again with 2 entries queued -> key_valid=0 and overflow=0 the next cycle, and no stale event follows.
